mdu_ctrl: RTL and testbench



---
 rtl/mdu_pkg.sv | 54 +++++
 rtl/mdu_calc.sv | 104 ++++++++++
 rtl/mdu_ctrl.sv | 140 ++++++++++++++
 tb/tb_mdu_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mdu_pkg
// Description : Shared definitions for the multiply/divide unit: operation
//               encoding, default latencies and operation-class helpers.
//               Optional macro MDU_MADD_EN widens the op code to 4 bits and
//               adds MADD/MADDU/MSUB/MSUBU.
// Revision    : 1.0 - initial release
// ============================================================================
package mdu_pkg;

`ifdef MDU_MADD_EN
    localparam int c_op_w = 4;
`else
    localparam int c_op_w = 3;
`endif

    typedef logic [c_op_w-1:0] mdu_op_t;

    localparam mdu_op_t c_op_nop   = mdu_op_t'(0);
    localparam mdu_op_t c_op_mult  = mdu_op_t'(1);
    localparam mdu_op_t c_op_multu = mdu_op_t'(2);
    localparam mdu_op_t c_op_div   = mdu_op_t'(3);
    localparam mdu_op_t c_op_divu  = mdu_op_t'(4);
    localparam mdu_op_t c_op_mthi  = mdu_op_t'(5);
    localparam mdu_op_t c_op_mtlo  = mdu_op_t'(6);
`ifdef MDU_MADD_EN
    localparam mdu_op_t c_op_madd  = mdu_op_t'(7);
    localparam mdu_op_t c_op_maddu = mdu_op_t'(8);
    localparam mdu_op_t c_op_msub  = mdu_op_t'(9);
    localparam mdu_op_t c_op_msubu = mdu_op_t'(10);
`endif

    localparam int c_mult_cycles_def = 5;
    localparam int c_div_cycles_def  = 10;

    // Divide-class ops use the longer latency
    function automatic logic is_div_op(input mdu_op_t op);
        return (op == c_op_div) || (op == c_op_divu);
    endfunction

    // Ops that occupy the unit for multiple cycles and produce a 64-bit result
    function automatic logic is_long_op(input mdu_op_t op);
        logic r;
        r = (op == c_op_mult) || (op == c_op_multu) || is_div_op(op);
`ifdef MDU_MADD_EN
        r = r || (op == c_op_madd) || (op == c_op_maddu) ||
                 (op == c_op_msub) || (op == c_op_msubu);
`endif
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mdu_calc.sv
`default_nettype none
// ============================================================================
// Module      : mdu_calc
// Description : Combinational 64-bit result generator for the MDU. Produces
//               {hi,lo} for multiply/divide (and multiply-accumulate when
//               MDU_MADD_EN is defined). o_res_valid is low for divide by
//               zero so the caller can leave HI/LO untouched.
// Revision    : 1.0 - initial release
// ============================================================================
module mdu_calc
    import mdu_pkg::*;
(
    input  mdu_op_t     i_op,
    input  logic [31:0] i_rs,
    input  logic [31:0] i_rt,
`ifdef MDU_MADD_EN
    input  logic [31:0] i_hi,
    input  logic [31:0] i_lo,
`endif
    output logic [31:0] o_res_hi,
    output logic [31:0] o_res_lo,
    output logic        o_res_valid
);

    logic [63:0] w_prod_s;
    logic [63:0] w_prod_u;
    logic        w_rs_neg;
    logic        w_rt_neg;
    logic [31:0] w_rs_mag;
    logic [31:0] w_rt_mag;
    logic [31:0] w_q_mag;
    logic [31:0] w_r_mag;
    logic [31:0] w_q_s;
    logic [31:0] w_r_s;
    logic [31:0] w_q_u;
    logic [31:0] w_r_u;
    logic        w_rt_zero;

    assign w_prod_s = $signed({{32{i_rs[31]}}, i_rs}) * $signed({{32{i_rt[31]}}, i_rt});
    assign w_prod_u = {32'd0, i_rs} * {32'd0, i_rt};

    // Signed divide is done on magnitudes so INT_MIN / -1 wraps cleanly to INT_MIN
    assign w_rs_neg  = i_rs[31];
    assign w_rt_neg  = i_rt[31];
    assign w_rs_mag  = w_rs_neg ? (32'd0 - i_rs) : i_rs;
    assign w_rt_mag  = w_rt_neg ? (32'd0 - i_rt) : i_rt;
    assign w_rt_zero = (i_rt == 32'd0);
    assign w_q_mag   = w_rt_zero ? 32'd0 : (w_rs_mag / w_rt_mag);
    assign w_r_mag   = w_rt_zero ? 32'd0 : (w_rs_mag % w_rt_mag);
    assign w_q_s     = (w_rs_neg ^ w_rt_neg) ? (32'd0 - w_q_mag) : w_q_mag;
    assign w_r_s     = w_rs_neg ? (32'd0 - w_r_mag) : w_r_mag;
    assign w_q_u     = w_rt_zero ? 32'd0 : (i_rs / i_rt);
    assign w_r_u     = w_rt_zero ? 32'd0 : (i_rs % i_rt);

    // Select the 64-bit result for the requested operation
    always_comb begin
        o_res_hi    = 32'd0;
        o_res_lo    = 32'd0;
        o_res_valid = 1'b0;
        case (i_op)
            c_op_mult: begin
                {o_res_hi, o_res_lo} = w_prod_s;
                o_res_valid          = 1'b1;
            end
            c_op_multu: begin
                {o_res_hi, o_res_lo} = w_prod_u;
                o_res_valid          = 1'b1;
            end
            c_op_div: begin
                o_res_hi    = w_r_s;
                o_res_lo    = w_q_s;
                o_res_valid = !w_rt_zero;
            end
            c_op_divu: begin
                o_res_hi    = w_r_u;
                o_res_lo    = w_q_u;
                o_res_valid = !w_rt_zero;
            end
`ifdef MDU_MADD_EN
            c_op_madd: begin
                {o_res_hi, o_res_lo} = {i_hi, i_lo} + w_prod_s;
                o_res_valid          = 1'b1;
            end
            c_op_maddu: begin
                {o_res_hi, o_res_lo} = {i_hi, i_lo} + w_prod_u;
                o_res_valid          = 1'b1;
            end
            c_op_msub: begin
                {o_res_hi, o_res_lo} = {i_hi, i_lo} - w_prod_s;
                o_res_valid          = 1'b1;
            end
            c_op_msubu: begin
                {o_res_hi, o_res_lo} = {i_hi, i_lo} - w_prod_u;
                o_res_valid          = 1'b1;
            end
`endif
            default: begin
                o_res_valid = 1'b0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mdu_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mdu_ctrl
// Description : Multiply/divide unit controller. Owns HI/LO, sequences the
//               multi-cycle busy window and raises the D-stage stall request.
//               Optional macro MDU_MADD_EN enables MADD/MADDU/MSUB/MSUBU.
// Revision    : 1.0 - initial release
// ============================================================================
module mdu_ctrl
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = c_mult_cycles_def,
    parameter int DIV_CYCLES  = c_div_cycles_def
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  mdu_op_t     mdu_op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        d_is_md,
    output logic        busy,
    output logic        md_stall,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int c_max_cycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int c_cnt_w      = $clog2(c_max_cycles + 1);

    localparam logic [c_cnt_w-1:0] c_cnt_zero = '0;
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
    localparam logic [c_cnt_w-1:0] c_mult_ld  = c_cnt_w'(MULT_CYCLES);
    localparam logic [c_cnt_w-1:0] c_div_ld   = c_cnt_w'(DIV_CYCLES);

    localparam logic [0:0] c_st_idle = 1'b0;
    localparam logic [0:0] c_st_busy = 1'b1;

    logic [0:0]         r_state;
    logic [0:0]         w_state_nxt;
    logic [c_cnt_w-1:0] r_count;
    logic [c_cnt_w-1:0] w_count_nxt;
    logic [31:0]        r_hi;
    logic [31:0]        r_lo;
    logic [31:0]        r_pend_hi;
    logic [31:0]        r_pend_lo;
    logic               r_pend_valid;
    logic [31:0]        w_res_hi;
    logic [31:0]        w_res_lo;
    logic               w_res_valid;
    logic               w_idle;
    logic               w_issue;
    logic               w_done;

    mdu_calc u_calc (
        .i_op        (mdu_op),
        .i_rs        (rs_val),
        .i_rt        (rt_val),
`ifdef MDU_MADD_EN
        .i_hi        (r_hi),
        .i_lo        (r_lo),
`endif
        .o_res_hi    (w_res_hi),
        .o_res_lo    (w_res_lo),
        .o_res_valid (w_res_valid)
    );

    assign w_idle  = (r_state == c_st_idle);
    assign w_issue = w_idle & start & is_long_op(mdu_op);
    assign w_done  = (r_state == c_st_busy) && (r_count == c_cnt_one);

    assign busy     = (r_state == c_st_busy);
    assign md_stall = d_is_md & (busy | (start & is_long_op(mdu_op)));
    assign hi       = r_hi;
    assign lo       = r_lo;

    // Next-state and counter: load latency on issue, count down while busy
    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        case (r_state)
            c_st_idle: begin
                if (w_issue) begin
                    w_state_nxt = c_st_busy;
                    w_count_nxt = is_div_op(mdu_op) ? c_div_ld : c_mult_ld;
                end
            end
            c_st_busy: begin
                w_count_nxt = r_count - c_cnt_one;
                if (r_count == c_cnt_one) begin
                    w_state_nxt = c_st_idle;
                end
            end
            default: begin
                w_state_nxt = c_st_idle;
                w_count_nxt = c_cnt_zero;
            end
        endcase
    end

    // State and counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_st_idle;
            r_count <= c_cnt_zero;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
        end
    end

    // HI/LO and pending result: capture at issue, commit on the last busy edge
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hi         <= 32'd0;
            r_lo         <= 32'd0;
            r_pend_hi    <= 32'd0;
            r_pend_lo    <= 32'd0;
            r_pend_valid <= 1'b0;
        end else begin
            if (w_issue) begin
                r_pend_hi    <= w_res_hi;
                r_pend_lo    <= w_res_lo;
                r_pend_valid <= w_res_valid;
            end
            if (w_done && r_pend_valid) begin
                r_hi <= r_pend_hi;
                r_lo <= r_pend_lo;
            end
            if (w_idle && start && (mdu_op == c_op_mthi)) begin
                r_hi <= rs_val;
            end
            if (w_idle && start && (mdu_op == c_op_mtlo)) begin
                r_lo <= rs_val;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mdu_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mdu_ctrl
// Description : Self-checking bench for mdu_ctrl: vector table of MDU ops
//               with a result scoreboard, plus hand sequences for MTHI/MTLO
//               back-to-back, start-while-busy and reset mid-operation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mdu_ctrl;
    import mdu_pkg::*;

    logic        clk;
    logic        reset;
    logic        start;
    mdu_op_t     mdu_op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        d_is_md;
    logic        busy;
    logic        md_stall;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        mdu_op_t     op;
        logic [31:0] rs;
        logic [31:0] rt;
        logic        dmd;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        int          exp_cycles;
    } vec_t;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cycles;
    } exp_t;

    vec_t vecs[12];
    exp_t sb_q[$];

    mdu_ctrl #(
        .MULT_CYCLES (5),
        .DIV_CYCLES  (10)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .mdu_op   (mdu_op),
        .rs_val   (rs_val),
        .rt_val   (rt_val),
        .d_is_md  (d_is_md),
        .busy     (busy),
        .md_stall (md_stall),
        .hi       (hi),
        .lo       (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Present an op for one cycle starting at a falling edge
    task automatic drive_op(input mdu_op_t op, input logic [31:0] rs, input logic [31:0] rt,
                            input logic dmd, input logic exp_stall);
        @(negedge clk);
        start   = 1'b1;
        mdu_op  = op;
        rs_val  = rs;
        rt_val  = rt;
        d_is_md = dmd;
        #1;
        check("issue_stall", {63'd0, md_stall}, {63'd0, exp_stall});
        @(posedge clk);
        #1;
        start  = 1'b0;
        mdu_op = c_op_nop;
    endtask

    // Count busy cycles at falling edges until busy drops; stall must track busy&d_is_md
    task automatic await_idle(input logic dmd, output int n, output logic stall_bad);
        n         = 0;
        stall_bad = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (!busy) break;
            n++;
            if (md_stall !== dmd) stall_bad = 1'b1;
        end
        if (busy) begin
            n_tests++;
            n_fail++;
            $display("FAIL busy_timeout: got busy=1 expected busy=0 within 40 cycles");
        end
    endtask

    initial begin
        exp_t        e;
        int          n;
        logic        sbad;

        vecs[0]  = '{c_op_mult,  32'hFFFFFFFE, 32'h00000003, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFA, 5};
        vecs[1]  = '{c_op_multu, 32'hFFFFFFFE, 32'h00000003, 1'b0, 32'h00000002, 32'hFFFFFFFA, 5};
        vecs[2]  = '{c_op_div,   32'hFFFFFFF9, 32'h00000002, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFD, 10};
        vecs[3]  = '{c_op_divu,  32'h00000007, 32'h00000000, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFD, 10};
        vecs[4]  = '{c_op_div,   32'h80000000, 32'hFFFFFFFF, 1'b0, 32'h00000000, 32'h80000000, 10};
        vecs[5]  = '{c_op_divu,  32'h00000064, 32'h00000007, 1'b1, 32'h00000002, 32'h0000000E, 10};
        vecs[6]  = '{c_op_div,   32'h00000007, 32'hFFFFFFFE, 1'b0, 32'h00000001, 32'hFFFFFFFD, 10};
        vecs[7]  = '{c_op_mult,  32'h80000000, 32'h80000000, 1'b1, 32'h40000000, 32'h00000000, 5};
        vecs[8]  = '{c_op_multu, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFE, 32'h00000001, 5};
        vecs[9]  = '{c_op_mthi,  32'h12345678, 32'h00000000, 1'b1, 32'h12345678, 32'h00000001, 0};
        vecs[10] = '{c_op_mtlo,  32'hCAFEF00D, 32'h00000000, 1'b0, 32'h12345678, 32'hCAFEF00D, 0};
        vecs[11] = '{c_op_nop,   32'h00000005, 32'h00000009, 1'b1, 32'h12345678, 32'hCAFEF00D, 0};

        reset   = 1'b1;
        start   = 1'b0;
        mdu_op  = c_op_nop;
        rs_val  = 32'd0;
        rt_val  = 32'd0;
        d_is_md = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_busy",  {63'd0, busy},     64'd0);
        check("reset_stall", {63'd0, md_stall}, 64'd0);
        check("reset_hi",    {32'd0, hi},       64'd0);
        check("reset_lo",    {32'd0, lo},       64'd0);
        reset = 1'b0;

        // Table-driven ops, results flow through the scoreboard
        for (int i = 0; i < 12; i++) begin
            sb_q.push_back('{vecs[i].exp_hi, vecs[i].exp_lo, vecs[i].exp_cycles});
            drive_op(vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].dmd,
                     vecs[i].dmd && (vecs[i].exp_cycles > 0));
            await_idle(vecs[i].dmd, n, sbad);
            if (sb_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL sb_empty: got 0 entries expected 1");
            end else begin
                e = sb_q.pop_front();
                check($sformatf("v%0d_cycles", i), 64'(n), 64'(e.cycles));
                check($sformatf("v%0d_stall", i),  {63'd0, sbad}, 64'd0);
                check($sformatf("v%0d_hi", i),     {32'd0, hi}, {32'd0, e.hi});
                check($sformatf("v%0d_lo", i),     {32'd0, lo}, {32'd0, e.lo});
                check($sformatf("v%0d_idle_stall", i), {63'd0, md_stall}, 64'd0);
            end
        end

        // MTHI then MTLO on consecutive cycles
        @(negedge clk);
        start = 1'b1; mdu_op = c_op_mthi; rs_val = 32'h12345678; d_is_md = 1'b0;
        @(negedge clk);
        check("mthi_hi",   {32'd0, hi},   64'h12345678);
        check("mthi_busy", {63'd0, busy}, 64'd0);
        mdu_op = c_op_mtlo; rs_val = 32'h9ABCDEF0;
        @(negedge clk);
        start = 1'b0; mdu_op = c_op_nop;
        check("mtlo_lo",   {32'd0, lo},   64'h9ABCDEF0);
        check("mtlo_hi",   {32'd0, hi},   64'h12345678);
        check("mtlo_busy", {63'd0, busy}, 64'd0);

        // Start while busy is ignored; MULT 6*7 still commits after 5 cycles
        sb_q.push_back('{32'h00000000, 32'h0000002A, 5});
        drive_op(c_op_mult, 32'd6, 32'd7, 1'b1, 1'b1);
        n = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (n == 3) begin
                start = 1'b0; mdu_op = c_op_nop;
            end
            if (!busy) break;
            n++;
            if (n == 2) begin
                start = 1'b1; mdu_op = c_op_divu; rs_val = 32'd100; rt_val = 32'd3;
            end
        end
        start = 1'b0; mdu_op = c_op_nop;
        e = sb_q.pop_front();
        check("swb_cycles", 64'(n), 64'(e.cycles));
        check("swb_hi", {32'd0, hi}, {32'd0, e.hi});
        check("swb_lo", {32'd0, lo}, {32'd0, e.lo});
        @(negedge clk);
        check("swb_no_rebusy", {63'd0, busy}, 64'd0);

        // Reset on the third busy cycle of a DIV discards the pending result
        drive_op(c_op_div, 32'd100, 32'd7, 1'b0, 1'b0);
        n = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (busy) n++;
        end
        check("rst_pre_busy", 64'(n), 64'd3);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_hi",   {32'd0, hi},   64'd0);
        check("rst_lo",   {32'd0, lo},   64'd0);
        sbad = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (busy || hi != 32'd0 || lo != 32'd0) sbad = 1'b1;
        end
        check("rst_no_commit", {63'd0, sbad}, 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
